// File: rtl/icache_pkg.sv
// icache_pkg: shared state encoding and address-field width helpers for the
// direct-mapped instruction cache.
package icache_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } state_e;

  // Word-offset width inside a line; line_words is a power of two >= 2.
  function automatic int off_w(input int line_words);
    return $clog2(line_words);
  endfunction

  // Line-index width; lines is a power of two >= 2.
  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction

  // Whatever is left of the word address above offset and index.
  function automatic int tag_w(input int addr_w, input int line_words, input int lines);
    return addr_w - off_w(line_words) - idx_w(lines);
  endfunction

endpackage

// File: rtl/icache_line_ram.sv
// icache_line_ram: tag and data arrays of the instruction cache.
// Writes are synchronous, reads are asynchronous so a hit costs no cycles.
module icache_line_ram
  import icache_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int LINES      = 16,
  parameter int ADDR_W     = 32,
  localparam int OFF_W     = off_w(LINE_WORDS),
  localparam int IDX_W     = idx_w(LINES),
  localparam int TAG_W     = tag_w(ADDR_W, LINE_WORDS, LINES)
) (
  input  logic             clock,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_index,
  input  logic [OFF_W-1:0] wr_word,
  input  logic [31:0]      wr_data,
  input  logic             tag_we,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [IDX_W-1:0] rd_index,
  input  logic [OFF_W-1:0] rd_word,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_data
);

  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [31:0]      data_mem [LINES][LINE_WORDS];

  // Arrays carry no reset; the valid bits in the top level guard them.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      data_mem[wr_index][wr_word] <= wr_data;
    end
    if (tag_we) begin
      tag_mem[wr_index] <= wr_tag;
    end
  end

  assign rd_tag  = tag_mem[rd_index];
  assign rd_data = data_mem[rd_index][rd_word];

endmodule

// File: rtl/icache.sv
// icache: direct-mapped, read-only instruction cache with whole-line refill
// over a strobe/ready memory handshake. Define ICACHE_STATS_EN to add the
// hit_count / miss_count statistics outputs.
module icache
  import icache_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int LINES      = 16,
  parameter int ADDR_W     = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              PStrobe,
  input  logic [ADDR_W-1:0] PAddress,
  output logic              PReady,
  output logic [31:0]       PData_out,
  input  logic              flush,
  output logic              SysStrobe,
  output logic [ADDR_W-1:0] SysAddress,
  input  logic              SysReady,
  input  logic [31:0]       SysData_in
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int OFF_W  = off_w(LINE_WORDS);
  localparam int IDX_W  = idx_w(LINES);
  localparam int TAG_W  = tag_w(ADDR_W, LINE_WORDS, LINES);
  localparam int LINE_W = ADDR_W - OFF_W;
  localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(LINE_WORDS - 1);

  state_e            state_q, state_d;
  logic [LINES-1:0]  valid_q, valid_d;
  logic [OFF_W-1:0]  cnt_q, cnt_d;
  logic [LINE_W-1:0] line_q, line_d;

  logic [OFF_W-1:0]  p_off;
  logic [IDX_W-1:0]  p_idx;
  logic [TAG_W-1:0]  p_tag;
  logic [IDX_W-1:0]  r_idx;
  logic [TAG_W-1:0]  r_tag;
  logic [TAG_W-1:0]  rd_tag;
  logic [31:0]       rd_data;
  logic              hit;
  logic              ram_we;
  logic              tag_we;

  assign p_off = PAddress[OFF_W-1:0];
  assign p_idx = PAddress[OFF_W +: IDX_W];
  assign p_tag = PAddress[ADDR_W-1 -: TAG_W];
  assign r_idx = line_q[IDX_W-1:0];
  assign r_tag = line_q[LINE_W-1 -: TAG_W];

  assign hit = PStrobe && valid_q[p_idx] && (rd_tag == p_tag);

  icache_line_ram #(
    .LINE_WORDS(LINE_WORDS),
    .LINES     (LINES),
    .ADDR_W    (ADDR_W)
  ) u_line_ram (
    .clock   (clock),
    .wr_en   (ram_we),
    .wr_index(r_idx),
    .wr_word (cnt_q),
    .wr_data (SysData_in),
    .tag_we  (tag_we),
    .wr_tag  (r_tag),
    .rd_index(p_idx),
    .rd_word (p_off),
    .rd_tag  (rd_tag),
    .rd_data (rd_data)
  );

  // Lookup in IDLE, in-order line refill in REFILL; flush overrides everything.
  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    cnt_d      = cnt_q;
    line_d     = line_q;
    ram_we     = 1'b0;
    tag_we     = 1'b0;
    PReady     = 1'b0;
    PData_out  = '0;
    SysStrobe  = 1'b0;
    SysAddress = '0;
    case (state_q)
      IDLE: begin
        PReady = !PStrobe || hit;
        if (hit) begin
          PData_out = rd_data;
        end
        if (PStrobe && !hit) begin
          line_d  = PAddress[ADDR_W-1:OFF_W];
          cnt_d   = '0;
          state_d = REFILL;
        end
      end
      REFILL: begin
        SysStrobe  = 1'b1;
        SysAddress = {line_q, cnt_q};
        if (SysReady) begin
          ram_we = 1'b1;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == LAST_WORD) begin
            tag_we         = 1'b1;
            valid_d[r_idx] = 1'b1;
            state_d        = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      valid_d = '0;
      state_d = IDLE;
      PReady  = 1'b0;
      ram_we  = 1'b0;
      tag_we  = 1'b0;
    end
  end

  // Control state register; an asynchronous reset abandons any refill.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      valid_q <= '0;
      cnt_q   <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  // Hits count every IDLE hit cycle, misses every IDLE to REFILL move.
  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (state_q == IDLE && hit) begin
      hit_count_d = hit_count_q + 32'd1;
    end
    if (state_q == IDLE && state_d == REFILL) begin
      miss_count_d = miss_count_q + 32'd1;
    end
  end

  // Statistics registers survive flush and clear only on reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_icache.sv
// tb_icache: directed and randomized checks of icache against a line-level
// reference model. Define ICACHE_STATS_EN to also check the statistics ports.
module tb_icache;

  localparam int LW = 4;
  localparam int NL = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        PStrobe = 1'b0;
  logic [31:0] PAddress = '0;
  logic        flush = 1'b0;
  logic        SysReady = 1'b0;
  logic [31:0] SysData_in;
  logic        PReady;
  logic [31:0] PData_out;
  logic        SysStrobe;
  logic [31:0] SysAddress;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int errors = 0;
  int checks = 0;

  bit          ref_valid [NL];
  logic [31:0] ref_line  [NL];
  int          ref_hits   = 0;
  int          ref_misses = 0;

  icache dut (
    .clock     (clock),
    .reset     (reset),
    .PStrobe   (PStrobe),
    .PAddress  (PAddress),
    .PReady    (PReady),
    .PData_out (PData_out),
    .flush     (flush),
    .SysStrobe (SysStrobe),
    .SysAddress(SysAddress),
    .SysReady  (SysReady),
    .SysData_in(SysData_in)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  always #5 clock = ~clock;

  // Instruction memory contents: a fixed scramble of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000 ^ {a[15:0], a[31:16]};
  endfunction

  assign SysData_in = mem_word(SysAddress);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_hit(input logic [31:0] addr);
    int idx;
    idx = int'((addr >> 2) & 32'hF);
    return ref_valid[idx] && (ref_line[idx] == (addr >> 2));
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < NL; i++) ref_valid[i] = 1'b0;
  endfunction

  task automatic check_stats(input string tag);
`ifdef ICACHE_STATS_EN
    check({tag, "_hit_count"}, hit_count, ref_hits);
    check({tag, "_miss_count"}, miss_count, ref_misses);
`else
    checks = checks + 0;
`endif
  endtask

  // One fetch: a hit completes at once, a miss is served by a memory that
  // raises SysReady on every period-th refill cycle.
  task automatic applyStimulus(input logic [31:0] addr, input int period);
    bit          exp_hit;
    bit          done;
    int          low;
    int          got;
    int          idx;
    logic [31:0] base;
    exp_hit = model_hit(addr);
    base    = addr & ~32'(LW - 1);
    done = 1'b0;
    low  = 0;
    got  = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clock);
      PStrobe  = 1'b1;
      PAddress = addr;
      flush    = 1'b0;
      SysReady = (c == 0) ? 1'b1 : (((c - 1) % period) == period - 1);
      #1;
      if (PReady) begin
        done = 1'b1;
        check("fetch_data", PData_out, mem_word(addr));
        check("hit_sysstrobe", {31'b0, SysStrobe}, 32'd0);
      end else begin
        low++;
        if (SysStrobe) begin
          check("sys_addr", SysAddress, base + 32'(got));
          if (SysReady) got++;
        end
      end
    end
    check("ready_low_cycles", 32'(low), exp_hit ? 32'd0 : 32'(1 + LW * period));
    check("refill_words", 32'(got), exp_hit ? 32'd0 : 32'(LW));
    @(posedge clock);
    idx = int'((addr >> 2) & 32'hF);
    if (!exp_hit) begin
      ref_misses++;
      ref_valid[idx] = 1'b1;
      ref_line[idx]  = addr >> 2;
    end
    if (done) ref_hits++;
  endtask

  task automatic idleCycle();
    @(negedge clock);
    PStrobe  = 1'b0;
    SysReady = 1'b0;
    flush    = 1'b0;
    #1;
    check("idle_ready", {31'b0, PReady}, 32'd1);
    check("idle_sysstrobe", {31'b0, SysStrobe}, 32'd0);
  endtask

  task automatic flushCycle();
    @(negedge clock);
    PStrobe = 1'b0;
    flush   = 1'b1;
    #1;
    check("flush_ready", {31'b0, PReady}, 32'd0);
    @(negedge clock);
    flush = 1'b0;
    model_clear();
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] ra;
    int          rp;
    int          rr;
    model_clear();

    // Reset state
    #2 reset = 1'b0;
    #10;
    check("rst_ready_idle", {31'b0, PReady}, 32'd1);
    check("rst_sysstrobe", {31'b0, SysStrobe}, 32'd0);
    check("rst_sysaddr", SysAddress, 32'd0);
    check("rst_pdata", PData_out, 32'd0);
    PStrobe  = 1'b1;
    PAddress = 32'h40;
    #1;
    check("rst_ready_strobe", {31'b0, PReady}, 32'd0);
    PStrobe = 1'b0;
    check_stats("rst");
    @(negedge clock);
    reset = 1'b1;

    // Cold miss, then same-line hits in consecutive cycles
    applyStimulus(32'h40, 1);
    applyStimulus(32'h41, 1);
    applyStimulus(32'h42, 1);
    applyStimulus(32'h43, 1);
    check_stats("same_line");

    // Conflict eviction on index 0
    applyStimulus(32'h140, 1);
    applyStimulus(32'h40, 1);

    // Wait states: SysReady every third cycle
    applyStimulus(32'h82, 3);
    applyStimulus(32'h80, 1);
    applyStimulus(32'h83, 2);

    // Flush while word 2 of a refill is pending
    @(negedge clock);
    PStrobe  = 1'b1;
    PAddress = 32'hC0;
    SysReady = 1'b1;
    #1;
    check("fm_miss_ready", {31'b0, PReady}, 32'd0);
    @(negedge clock);
    #1;
    check("fm_word0", SysAddress, 32'hC0);
    @(negedge clock);
    #1;
    check("fm_word1", SysAddress, 32'hC1);
    @(negedge clock);
    flush = 1'b1;
    #1;
    check("fm_word2_strobe", {31'b0, SysStrobe}, 32'd1);
    check("fm_word2", SysAddress, 32'hC2);
    check("fm_ready", {31'b0, PReady}, 32'd0);
    @(negedge clock);
    flush    = 1'b0;
    SysReady = 1'b0;
    PStrobe  = 1'b0;
    #1;
    check("fm_strobe_drop", {31'b0, SysStrobe}, 32'd0);
    ref_misses++;
    model_clear();
    applyStimulus(32'hC0, 1);
    applyStimulus(32'h40, 1);
    check_stats("after_flush");

    // Flush while idle invalidates the filled line
    flushCycle();
    applyStimulus(32'hC1, 2);

    // Asynchronous reset in the middle of a refill
    @(negedge clock);
    PStrobe  = 1'b1;
    PAddress = 32'h240;
    SysReady = 1'b1;
    @(negedge clock);
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    check("ar_sysstrobe", {31'b0, SysStrobe}, 32'd0);
    check("ar_sysaddr", SysAddress, 32'd0);
    check("ar_ready", {31'b0, PReady}, 32'd0);
    check("ar_pdata", PData_out, 32'd0);
    PStrobe = 1'b0;
    #1;
    check("ar_ready_idle", {31'b0, PReady}, 32'd1);
    model_clear();
    ref_hits   = 0;
    ref_misses = 0;
    check_stats("ar_reset");
    @(negedge clock);
    reset = 1'b1;
    applyStimulus(32'h240, 1);
    applyStimulus(32'h241, 1);
    applyStimulus(32'h243, 1);
    check_stats("ar_three_hits");

    // Randomized fetch stream over a small address window
    for (int n = 0; n < 60; n++) begin
      ra = 32'($urandom_range(0, 511));
      rp = int'($urandom_range(1, 3));
      rr = int'($urandom_range(0, 9));
      if (rr == 0) flushCycle();
      else if (rr == 1) idleCycle();
      applyStimulus(ra, rp);
    end
    check_stats("final");
    idleCycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache between the PC stage and instruction memory. It is the fetch-side counterpart of `dcache`. It takes word addresses from the PC and returns instructions to the REG1 pipeline wall. `PReady` is ANDed into `enable_system` so that the whole pipeline freezes during a refill. On a miss it refills a whole line from instruction memory over a strobe/ready handshake.

## Interface
- `LINE_WORDS`, 4: words per line; power of two, at least 2.
- `LINES`, 16: number of lines; power of two.
- `ADDR_W`, 32: width of the processor word address.
- `clock` input 1: the single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset. All state clears immediately while low.
- `PStrobe` input 1: fetch request.
- `PAddress` input `ADDR_W`: word address of the fetch.
- `PReady` output 1: instruction valid this cycle, or no request pending.
- `PData_out` output 32: instruction word.
- `flush` input 1: invalidate every line.
- `SysStrobe` output 1: memory read request.
- `SysAddress` output `ADDR_W`: memory word address.
- `SysReady` input 1: memory has returned `SysData_in` this cycle.
- `SysData_in` input 32: memory read data.

## Operation
- Address split:
  - offset = `PAddress[OFF_W-1:0]`, where `OFF_W` = log2(`LINE_WORDS`).
  - index = next `IDX_W` bits, where `IDX_W` = log2(`LINES`).
  - tag = the remaining upper bits.
- Storage:
  - valid bit per line, reset to 0.
  - tag array and data array; contents are undefined after reset.
- States: `IDLE`, `REFILL`.
- `IDLE` behaviour:
  - hit = `PStrobe` && valid[index] && tag match.
  - `PReady` = !`PStrobe` || hit (combinational).
  - `PData_out` = data[index][offset] on a hit, else 0.
  - On a miss: latch the line base address (`PAddress` with offset zeroed), clear the word counter to 0, and go to `REFILL`.
- `REFILL` behaviour:
  - `PReady` = 0 and `PData_out` = 0.
  - `SysStrobe` = 1 and `SysAddress` = line base + word counter.
  - When `SysReady` = 1 at an edge: write `SysData_in` into data[index][counter] and increment the counter.
  - Edge at which the last word is accepted: set valid[index], write the tag, go to `IDLE`.
- Words are fetched in order 0 to `LINE_WORDS`-1; there is no critical-word-first.
- The refill uses the latched address. Changes on `PAddress` during `REFILL` are ignored. The lookup is redone in `IDLE` with whatever address is current.
- `flush` has priority over all other activity:
  - clears all valid bits at the edge.
  - forces `PReady` = 0 in that cycle.
  - aborts any refill: go to `IDLE`, no valid bit set, `SysStrobe` drops in the next cycle.
- Memory is never written; there is no write path.

## Timing
- Reset values: state `IDLE`, all valid bits 0, word counter 0, `SysStrobe` 0, `SysAddress` 0, `PData_out` 0.
- After reset, `PReady` = !`PStrobe`.
- Hit latency: 0 cycles; `PReady` and the data are combinational from the address.
- Miss sequence with `SysReady` tied to 1 and `LINE_WORDS` = 4:
  - Cycle 0 is the miss. Cycles 1–4 are `REFILL`, one word per cycle.
  - Cycle 5 is a hit.
  - `PReady` is low for 5 cycles. In general it is low for 1 + `LINE_WORDS` + total wait cycles.
- Sys handshake:
  - `SysStrobe` and `SysAddress` stay stable until `SysReady` is sampled high.
  - `SysStrobe` may stay high between words; the address steps by 1.
  - `SysReady` is ignored while `SysStrobe` = 0.
- If `reset` is asserted mid-refill, the refill is abandoned asynchronously and that line stays invalid.
- Address wrap: the line base plus counter never crosses a line boundary, so there is no carry out of the offset field.

## Configuration
- `ICACHE_STATS_EN` defined:
  - adds output `hit_count` (32 bits), which increments on each `IDLE` cycle with a hit.
  - adds output `miss_count` (32 bits), which increments on each `IDLE`→`REFILL` transition.
  - both counters reset to 0, wrap modulo 2^32, and are not cleared by `flush`.
- `ICACHE_STATS_EN` undefined: these ports and counters do not exist.
- Cache behaviour is identical in both builds.

## Structure
- Package `icache_pkg` holds:
  - the state enum (`IDLE`, `REFILL`).
  - the derived-width functions for `OFF_W`, `IDX_W` and `TAG_W`.
- Sub-module `icache_line_ram` holds the tag and data arrays:
  - synchronous write, asynchronous read.
  - write ports are index, word select, data, tag write-enable.
- The top level holds the FSM, the valid bits, the counter and the stats logic.

## Test plan
- Cold miss: after reset, fetch 0x40 with `SysReady` = 1 → `SysAddress` goes 0x40, 0x41, 0x42, 0x43; `PReady` low for 5 cycles; then `PData_out` = memory[0x40].
- Same-line hits: after the line is filled, fetch 0x41, 0x42, 0x43 in consecutive cycles → `PReady` = 1 every cycle with the correct words; `SysStrobe` stays 0.
- Conflict eviction with `LINES` = 16, `LINE_WORDS` = 4: fill 0x40, then fetch 0x140 → miss and refill; fetch 0x40 again → miss again.
- Wait states: `SysReady` high only every third cycle → each word is held until accepted; `PReady` low for 1 + 4×3 cycles; data is correct.
- Flush mid-refill: assert `flush` while word 2 is pending → `SysStrobe` drops next cycle; refetch of the same address misses and does a full 4-word refill.
- Async reset mid-refill: drop `reset` between edges → outputs go to their reset values immediately; with `ICACHE_STATS_EN`, 3 hits and 1 miss read `hit_count` = 3, `miss_count` = 1.
